systolic_output_deskew: RTL

- Downstream consumer of the systolic array's south edge. Column j of a result row leaves the array one cycle after column j-1.
- Delays each column so the whole row lines up, then buffers aligned rows in a small FIFO with a valid/ready output.
- The array cannot stall, so the FIFO absorbs short backpressure and flags overflow; it never pushes back upstream.

---
 rtl/systolic_output_deskew.sv | 130 +++++++++++++
 1 files changed

// File: rtl/systolic_output_deskew.sv
// South-edge deskew for the systolic array: per-column delay lines line up each
// result row, then a small FIFO presents aligned rows with valid/ready.
module systolic_output_deskew #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [31:0]              sys_data_in [SYSTOLIC_ARRAY_WIDTH],
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0] sys_valid_in,
  input  logic [15:0]                     col_size_in,
  input  logic                            col_size_valid_in,
  input  logic                            sticky_clr,
  output logic signed [31:0]              row_data_out [SYSTOLIC_ARRAY_WIDTH],
  output logic                            row_valid_out,
  input  logic                            row_ready_in,
  output logic [15:0]                     row_count_out,
  output logic                            overflow_err,
  output logic                            misalign_err
);
  localparam int          N    = SYSTOLIC_ARRAY_WIDTH;
  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [15:0] N_16 = 16'(N);

  logic [15:0]        col_size_reg;
  logic [N-1:0][31:0] align_data;
  logic [N-1:0]       align_valid;
  logic [N-1:0][31:0] row_next;
  logic [N-1:0]       col_mismatch;
  logic [N-1:0][31:0] fifo_mem [FIFO_DEPTH];
  logic [N-1:0][31:0] fifo_head;
  logic [AW:0]        wr_ptr_reg;
  logic [AW:0]        rd_ptr_reg;
  logic               fifo_empty;
  logic               fifo_full;
  logic               row_wr;
  logic               row_pop;
  logic               row_push;
  logic               overflow_evt;
  logic               misalign_evt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      // Column gi leaves the array gi cycles after column 0, so it waits N-1-gi cycles.
      localparam int DEPTH = N - 1 - gi;
      logic [31:0] col_align_data_reg;
      logic        col_align_valid_reg;

      if (DEPTH == 0) begin : g_direct
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            col_align_data_reg  <= '0;
            col_align_valid_reg <= 1'b0;
          end else begin
            col_align_data_reg  <= sys_data_in[gi];
            col_align_valid_reg <= sys_valid_in[gi];
          end
        end
      end else begin : g_delay
        logic [31:0]      dly_data_reg [DEPTH];
        logic [DEPTH-1:0] dly_valid_reg;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            for (int k = 0; k < DEPTH; k++) dly_data_reg[k] <= '0;
            dly_valid_reg       <= '0;
            col_align_data_reg  <= '0;
            col_align_valid_reg <= 1'b0;
          end else begin
            dly_data_reg[0]  <= sys_data_in[gi];
            dly_valid_reg[0] <= sys_valid_in[gi];
            for (int k = 1; k < DEPTH; k++) begin
              dly_data_reg[k]  <= dly_data_reg[k-1];
              dly_valid_reg[k] <= dly_valid_reg[k-1];
            end
            col_align_data_reg  <= dly_data_reg[DEPTH-1];
            col_align_valid_reg <= dly_valid_reg[DEPTH-1];
          end
        end
      end

      assign align_data[gi]   = col_align_data_reg;
      assign align_valid[gi]  = col_align_valid_reg;
      // Inactive columns are zeroed and excluded from the alignment check.
      assign row_next[gi]     = (16'(gi) < col_size_reg) ? align_data[gi] : '0;
      assign col_mismatch[gi] = (16'(gi) < col_size_reg) && (align_valid[gi] != align_valid[0]);
      assign row_data_out[gi] = fifo_empty ? '0 : fifo_head[gi];
    end
  endgenerate

  assign row_wr       = align_valid[0] && (col_size_reg != 16'd0);
  assign misalign_evt = |col_mismatch;

  assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_head    = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign row_pop      = !fifo_empty && row_ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign overflow_evt = row_wr && fifo_full && !row_pop;
  assign row_push     = row_wr && !overflow_evt;
  assign row_valid_out = !fifo_empty;

  always_ff @(posedge clk) begin
    if (row_push) fifo_mem[wr_ptr_reg[AW-1:0]] <= row_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_size_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      row_count_out <= '0;
      overflow_err  <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      if (col_size_valid_in)
        col_size_reg <= (col_size_in > N_16) ? N_16 : col_size_in;
      if (row_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (row_pop) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        row_count_out <= row_count_out + 16'd1;
      end
      overflow_err <= overflow_evt | (overflow_err & ~sticky_clr);
      misalign_err <= misalign_evt | (misalign_err & ~sticky_clr);
    end
  end

endmodule
